// File: rtl/writeback_store_buffer.sv
// Writeback stage with an in-order store buffer.
// Retires one instruction per cycle into the register file (primary and
// special destination, plus in-use bit clearing). Stores are queued in a
// DEPTH-entry circular buffer and drained to the data cache one at a time
// over the reqcyc/reqack/writeack handshake. Loads in the memory stage can
// forward from the youngest buffered store to the same address.
module writeback_store_buffer #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int NREGS  = 16,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 16,
    parameter logic [TAG_W-1:0] WRITE_TAG = 16'h0000,
    localparam int REG_W = $clog2(NREGS),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_kill,
    input  logic              wb_dest_valid,
    input  logic [REG_W-1:0]  wb_dest_reg,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              wb_spec_valid,
    input  logic [REG_W-1:0]  wb_spec_reg,
    input  logic [DATA_W-1:0] wb_spec_result,
    input  logic [NREGS-1:0]  wb_clr_mask,
    input  logic              wb_is_store,
    input  logic [ADDR_W-1:0] wb_store_addr,
    input  logic [DATA_W-1:0] wb_store_data,
    output logic              rf_we0,
    output logic [REG_W-1:0]  rf_idx0,
    output logic [DATA_W-1:0] rf_data0,
    output logic              rf_we1,
    output logic [REG_W-1:0]  rf_idx1,
    output logic [DATA_W-1:0] rf_data1,
    output logic [NREGS-1:0]  inuse_clr,
    output logic              wb_done,
    output logic              reqcyc,
    output logic [ADDR_W-1:0] req,
    output logic [DATA_W-1:0] reqdata,
    output logic [TAG_W-1:0]  reqtag,
    input  logic              reqack,
    input  logic              writeack,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  store_count,
    output logic              store_done,
    output logic              drained
);

    localparam int PTR_W = $clog2(DEPTH);

    // Drain FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // One-hot in-use clear bit for a register, or nothing when not enabled.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] idx,
                                                    input logic en);
        logic [NREGS-1:0] v;
        v = {NREGS{1'b0}};
        if (en) begin
            v[idx] = 1'b1;
        end else begin
            v = {NREGS{1'b0}};
        end
        return v;
    endfunction

    // Retire path state
    logic              rf_we0_q, rf_we0_d;
    logic [REG_W-1:0]  rf_idx0_q, rf_idx0_d;
    logic [DATA_W-1:0] rf_data0_q, rf_data0_d;
    logic              rf_we1_q, rf_we1_d;
    logic [REG_W-1:0]  rf_idx1_q, rf_idx1_d;
    logic [DATA_W-1:0] rf_data1_q, rf_data1_d;
    logic [NREGS-1:0]  inuse_clr_q, inuse_clr_d;
    logic              wb_done_q, wb_done_d;

    // Store buffer state
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_d [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Drain FSM and cache request registers
    logic [1:0]        state_q, state_d;
    logic              reqcyc_q, reqcyc_d;
    logic [ADDR_W-1:0] req_q, req_d;
    logic [DATA_W-1:0] reqdata_q, reqdata_d;
    logic [TAG_W-1:0]  reqtag_q, reqtag_d;
    logic              store_done_q, store_done_d;

    logic              wb_ready_s;
    logic              accept_s;
    logic              enq_s;
    logic              pop_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic              fwd_match_s;

    // Handshake decode: readiness comes only from the registered count
    always_comb begin
        wb_ready_s = (count_q < FULL_CNT);
        accept_s   = wb_valid && wb_ready_s;
        enq_s      = accept_s && !wb_kill && wb_is_store;
        pop_s      = (state_q == S_DONE);
    end

    // Next-cycle RF writes, in-use clears and retire pulse for an accepted instruction
    always_comb begin
        rf_we0_d = accept_s && !wb_kill && wb_dest_valid && !wb_is_store;
        rf_we1_d = accept_s && !wb_kill && wb_spec_valid;
        if (rf_we0_d) begin
            rf_idx0_d  = wb_dest_reg;
            rf_data0_d = wb_result;
        end else begin
            rf_idx0_d  = {REG_W{1'b0}};
            rf_data0_d = {DATA_W{1'b0}};
        end
        if (rf_we1_d) begin
            rf_idx1_d  = wb_spec_reg;
            rf_data1_d = wb_spec_result;
        end else begin
            rf_idx1_d  = {REG_W{1'b0}};
            rf_data1_d = {DATA_W{1'b0}};
        end
        // Clears apply even to squashed instructions so the scoreboard never leaks bits
        if (accept_s) begin
            inuse_clr_d = wb_clr_mask
                        | reg_onehot(wb_dest_reg, wb_dest_valid)
                        | reg_onehot(wb_spec_reg, wb_spec_valid);
        end else begin
            inuse_clr_d = {NREGS{1'b0}};
        end
        wb_done_d = accept_s;
    end

    // Circular buffer: enqueue at tail, pop at head, count tracks occupancy
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (enq_s) begin
            addr_mem_d[tail_q] = wb_store_addr;
            data_mem_d[tail_q] = wb_store_data;
            tail_d             = tail_q + ONE_PTR;
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + ONE_PTR;
        end else begin
            head_d = head_q;
        end
        case ({enq_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: issue head entry, wait for accept and write completion, then pop
    always_comb begin
        state_d      = state_q;
        reqcyc_d     = reqcyc_q;
        req_d        = req_q;
        reqdata_d    = reqdata_q;
        reqtag_d     = reqtag_q;
        store_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != ZERO_CNT) begin
                    state_d   = S_REQ;
                    reqcyc_d  = 1'b1;
                    req_d     = addr_mem_q[head_q];
                    reqdata_d = data_mem_q[head_q];
                    reqtag_d  = WRITE_TAG;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (reqack) begin
                    reqcyc_d = 1'b0;
                    if (writeack) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (writeack) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                store_done_d = 1'b1;
            end
            default: begin
                state_d  = S_IDLE;
                reqcyc_d = 1'b0;
            end
        endcase
    end

    // Forwarding scan from oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit_s   = 1'b0;
        fwd_data_s  = {DATA_W{1'b0}};
        fwd_idx_s   = head_q;
        fwd_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s   = head_q + PTR_W'(i);
            fwd_match_s = (CNT_W'(i) < count_q) && (addr_mem_q[fwd_idx_s] == fwd_addr);
            fwd_hit_s   = fwd_hit_s | fwd_match_s;
            fwd_data_s  = fwd_match_s ? data_mem_q[fwd_idx_s] : fwd_data_s;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we0_q     <= 1'b0;
            rf_idx0_q    <= {REG_W{1'b0}};
            rf_data0_q   <= {DATA_W{1'b0}};
            rf_we1_q     <= 1'b0;
            rf_idx1_q    <= {REG_W{1'b0}};
            rf_data1_q   <= {DATA_W{1'b0}};
            inuse_clr_q  <= {NREGS{1'b0}};
            wb_done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= {ADDR_W{1'b0}};
                data_mem_q[i] <= {DATA_W{1'b0}};
            end
            head_q       <= {PTR_W{1'b0}};
            tail_q       <= {PTR_W{1'b0}};
            count_q      <= ZERO_CNT;
            state_q      <= S_IDLE;
            reqcyc_q     <= 1'b0;
            req_q        <= {ADDR_W{1'b0}};
            reqdata_q    <= {DATA_W{1'b0}};
            reqtag_q     <= {TAG_W{1'b0}};
            store_done_q <= 1'b0;
        end else begin
            rf_we0_q     <= rf_we0_d;
            rf_idx0_q    <= rf_idx0_d;
            rf_data0_q   <= rf_data0_d;
            rf_we1_q     <= rf_we1_d;
            rf_idx1_q    <= rf_idx1_d;
            rf_data1_q   <= rf_data1_d;
            inuse_clr_q  <= inuse_clr_d;
            wb_done_q    <= wb_done_d;
            addr_mem_q   <= addr_mem_d;
            data_mem_q   <= data_mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            reqcyc_q     <= reqcyc_d;
            req_q        <= req_d;
            reqdata_q    <= reqdata_d;
            reqtag_q     <= reqtag_d;
            store_done_q <= store_done_d;
        end
    end

    assign wb_ready    = wb_ready_s;
    assign rf_we0      = rf_we0_q;
    assign rf_idx0     = rf_idx0_q;
    assign rf_data0    = rf_data0_q;
    assign rf_we1      = rf_we1_q;
    assign rf_idx1     = rf_idx1_q;
    assign rf_data1    = rf_data1_q;
    assign inuse_clr   = inuse_clr_q;
    assign wb_done     = wb_done_q;
    assign reqcyc      = reqcyc_q;
    assign req         = req_q;
    assign reqdata     = reqdata_q;
    assign reqtag      = reqtag_q;
    assign store_done  = store_done_q;
    assign store_count = count_q;
    assign fwd_hit     = fwd_hit_s;
    assign fwd_data    = fwd_data_s;
    assign drained     = (count_q == ZERO_CNT) && (state_q == S_IDLE);

endmodule

// File: tb/tb_writeback_store_buffer.sv
// Self-checking bench for writeback_store_buffer (default parameters).
// A queue-based model predicts every output each cycle; directed tests add
// hand-computed literal checks.
module tb_writeback_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_valid = 1'b0, wb_kill = 1'b0;
    logic        wb_dest_valid = 1'b0, wb_spec_valid = 1'b0, wb_is_store = 1'b0;
    logic [3:0]  wb_dest_reg = 4'd0, wb_spec_reg = 4'd0;
    logic [63:0] wb_result = 64'd0, wb_spec_result = 64'd0;
    logic [15:0] wb_clr_mask = 16'd0;
    logic [63:0] wb_store_addr = 64'd0, wb_store_data = 64'd0;
    logic        reqack = 1'b0, writeack = 1'b0;
    logic [63:0] fwd_addr = 64'd0;

    logic        wb_ready, rf_we0, rf_we1, wb_done, reqcyc, fwd_hit, store_done, drained;
    logic [3:0]  rf_idx0, rf_idx1;
    logic [63:0] rf_data0, rf_data1, req, reqdata, fwd_data;
    logic [15:0] inuse_clr, reqtag;
    logic [2:0]  store_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    writeback_store_buffer dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kill(wb_kill),
        .wb_dest_valid(wb_dest_valid), .wb_dest_reg(wb_dest_reg), .wb_result(wb_result),
        .wb_spec_valid(wb_spec_valid), .wb_spec_reg(wb_spec_reg), .wb_spec_result(wb_spec_result),
        .wb_clr_mask(wb_clr_mask),
        .wb_is_store(wb_is_store), .wb_store_addr(wb_store_addr), .wb_store_data(wb_store_data),
        .rf_we0(rf_we0), .rf_idx0(rf_idx0), .rf_data0(rf_data0),
        .rf_we1(rf_we1), .rf_idx1(rf_idx1), .rf_data1(rf_data1),
        .inuse_clr(inuse_clr), .wb_done(wb_done),
        .reqcyc(reqcyc), .req(req), .reqdata(reqdata), .reqtag(reqtag),
        .reqack(reqack), .writeack(writeack),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .store_count(store_count), .store_done(store_done), .drained(drained)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mq_addr[$];
    logic [63:0] mq_data[$];
    bit          m_live = 1'b0;
    bit          m_req = 1'b0, m_wait = 1'b0, m_pop = 1'b0;
    bit          e_sd = 1'b0, e_done = 1'b0, e_we0 = 1'b0, e_we1 = 1'b0;
    logic [3:0]  e_idx0 = 4'd0, e_idx1 = 4'd0;
    logic [63:0] e_d0 = 64'd0, e_d1 = 64'd0, m_raddr = 64'd0, m_rdata = 64'd0;
    logic [15:0] e_inuse = 16'd0;

    initial begin
        bit acc;
        forever begin
            @(posedge clk);
            if (!reset) begin
                mq_addr.delete();
                mq_data.delete();
                m_req = 0; m_wait = 0; m_pop = 0; e_sd = 0;
                e_done = 0; e_we0 = 0; e_we1 = 0; e_inuse = 16'd0;
                m_live = 1;
            end else begin
                acc     = wb_valid && (mq_addr.size() < DEPTH);
                e_done  = acc;
                e_inuse = acc ? (wb_clr_mask
                                 | (wb_dest_valid ? (16'h0001 << wb_dest_reg) : 16'h0000)
                                 | (wb_spec_valid ? (16'h0001 << wb_spec_reg) : 16'h0000))
                              : 16'h0000;
                e_we0  = acc && !wb_kill && wb_dest_valid && !wb_is_store;
                e_idx0 = wb_dest_reg; e_d0 = wb_result;
                e_we1  = acc && !wb_kill && wb_spec_valid;
                e_idx1 = wb_spec_reg; e_d1 = wb_spec_result;
                // drain progress, judged on the occupancy before this edge's enqueue
                e_sd = m_pop;
                if (m_pop) begin
                    void'(mq_addr.pop_front());
                    void'(mq_data.pop_front());
                    m_pop = 0;
                end else if (m_req) begin
                    if (reqack) begin
                        m_req = 0;
                        if (writeack) m_pop = 1; else m_wait = 1;
                    end
                end else if (m_wait) begin
                    if (writeack) begin m_wait = 0; m_pop = 1; end
                end else if (mq_addr.size() > 0) begin
                    m_req = 1; m_raddr = mq_addr[0]; m_rdata = mq_data[0];
                end
                if (acc && !wb_kill && wb_is_store) begin
                    mq_addr.push_back(wb_store_addr);
                    mq_data.push_back(wb_store_data);
                end
            end
        end
    end

    // every-cycle comparison against the model
    initial begin
        bit          h;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (m_live) begin
                h = 0; d = 64'd0;
                for (int i = 0; i < mq_addr.size(); i++) begin
                    if (mq_addr[i] == fwd_addr) begin h = 1; d = mq_data[i]; end
                end
                chk("m_wb_ready", wb_ready, mq_addr.size() < DEPTH);
                chk("m_store_count", store_count, mq_addr.size());
                chk("m_drained", drained, (mq_addr.size() == 0) && !m_req && !m_wait && !m_pop);
                chk("m_reqcyc", reqcyc, m_req);
                if (m_req) begin
                    chk("m_req", req, m_raddr);
                    chk("m_reqdata", reqdata, m_rdata);
                    chk("m_reqtag", reqtag, 16'h0000);
                end
                chk("m_store_done", store_done, e_sd);
                chk("m_wb_done", wb_done, e_done);
                chk("m_inuse_clr", inuse_clr, e_inuse);
                chk("m_rf_we0", rf_we0, e_we0);
                if (e_we0) begin
                    chk("m_rf_idx0", rf_idx0, e_idx0);
                    chk("m_rf_data0", rf_data0, e_d0);
                end
                chk("m_rf_we1", rf_we1, e_we1);
                if (e_we1) begin
                    chk("m_rf_idx1", rf_idx1, e_idx1);
                    chk("m_rf_data1", rf_data1, e_d1);
                end
                chk("m_fwd_hit", fwd_hit, h);
                chk("m_fwd_data", fwd_data, d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        wb_valid = 0; wb_kill = 0; wb_dest_valid = 0; wb_spec_valid = 0;
        wb_is_store = 0; wb_clr_mask = 16'd0;
    endtask

    task automatic put_store(input logic [63:0] a, input logic [63:0] d);
        clr_in();
        wb_valid = 1; wb_is_store = 1; wb_store_addr = a; wb_store_data = d;
        step();
        clr_in();
    endtask

    task automatic wait_reqcyc();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (reqcyc) break;
        end
        chk("wait_reqcyc", reqcyc, 1'b1);
    endtask

    task automatic wait_drained();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (drained) break;
        end
        chk("wait_drained", drained, 1'b1);
    endtask

    task automatic drain_one(input logic [63:0] a, input logic [63:0] d);
        wait_reqcyc();
        chk("fifo_req", req, a);
        chk("fifo_reqdata", reqdata, d);
        reqack = 1; step(); reqack = 0;
        repeat (3) step();
        writeack = 1; step(); writeack = 0;
    endtask

    logic [63:0] t3_addr [5] = '{64'hA000, 64'hA008, 64'hA010, 64'hA018, 64'hA020};
    logic [63:0] t3_data [5] = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55};

    // ---------------- directed tests ----------------
    initial begin
        // reset
        repeat (2) step();
        @(negedge clk);
        chk("rst_wb_ready", wb_ready, 1'b1);
        chk("rst_drained", drained, 1'b1);
        chk("rst_reqcyc", reqcyc, 1'b0);
        chk("rst_count", store_count, 3'd0);
        chk("rst_inuse", inuse_clr, 16'h0000);
        reset = 1;
        step();

        // ALU op with both destinations
        wb_valid = 1; wb_dest_valid = 1; wb_dest_reg = 4'd3; wb_result = 64'hDEAD_BEEF;
        wb_spec_valid = 1; wb_spec_reg = 4'd2; wb_spec_result = 64'd5; wb_clr_mask = 16'h0011;
        step();
        clr_in();
        @(negedge clk);
        chk("alu_we0", rf_we0, 1'b1);
        chk("alu_idx0", rf_idx0, 4'd3);
        chk("alu_data0", rf_data0, 64'hDEAD_BEEF);
        chk("alu_we1", rf_we1, 1'b1);
        chk("alu_idx1", rf_idx1, 4'd2);
        chk("alu_data1", rf_data1, 64'd5);
        chk("alu_inuse", inuse_clr, 16'h001D);
        chk("alu_done", wb_done, 1'b1);
        @(negedge clk);
        chk("alu_done_pulse", wb_done, 1'b0);

        // single store, same-cycle reqack+writeack
        put_store(64'h1000, 64'h55);
        reqack = 1; writeack = 1;
        wait_reqcyc();
        chk("st_req", req, 64'h1000);
        chk("st_reqdata", reqdata, 64'h55);
        chk("st_reqtag", reqtag, 16'h0000);
        @(negedge clk);
        chk("st_reqcyc_one", reqcyc, 1'b0);
        chk("st_done_early", store_done, 1'b0);
        @(negedge clk);
        chk("st_done", store_done, 1'b1);
        chk("st_drained", drained, 1'b1);
        reqack = 0; writeack = 0;

        // DEPTH+1 stores with reqack withheld
        for (int k = 0; k < 4; k++) put_store(t3_addr[k], t3_data[k]);
        @(negedge clk);
        chk("full_ready", wb_ready, 1'b0);
        chk("full_count", store_count, 3'd4);
        wb_valid = 1; wb_is_store = 1; wb_store_addr = t3_addr[4]; wb_store_data = t3_data[4];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_no_done", wb_done, 1'b0);
        end
        drain_one(t3_addr[0], t3_data[0]);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (wb_ready) break;
        end
        step();
        clr_in();
        @(negedge clk);
        chk("fifth_done", wb_done, 1'b1);
        chk("fifth_count", store_count, 3'd4);
        for (int k = 1; k < 5; k++) drain_one(t3_addr[k], t3_data[k]);
        wait_drained();

        // forwarding
        put_store(64'h2000, 64'd1);
        put_store(64'h3000, 64'd2);
        put_store(64'h2000, 64'd9);
        fwd_addr = 64'h2000;
        @(negedge clk);
        chk("fwd_hit_2000", fwd_hit, 1'b1);
        chk("fwd_data_2000", fwd_data, 64'd9);
        fwd_addr = 64'h3000;
        @(negedge clk);
        chk("fwd_data_3000", fwd_data, 64'd2);
        fwd_addr = 64'h4000;
        @(negedge clk);
        chk("fwd_hit_4000", fwd_hit, 1'b0);
        chk("fwd_data_4000", fwd_data, 64'd0);
        // store carrying a special destination
        clr_in();
        wb_valid = 1; wb_is_store = 1; wb_store_addr = 64'h4000; wb_store_data = 64'h77;
        wb_dest_valid = 1; wb_dest_reg = 4'd4; wb_spec_valid = 1; wb_spec_reg = 4'd9;
        wb_spec_result = 64'h1234;
        step();
        clr_in();
        @(negedge clk);
        chk("st_spec_we0", rf_we0, 1'b0);
        chk("st_spec_we1", rf_we1, 1'b1);
        chk("fwd_new_4000", fwd_data, 64'h77);
        reqack = 1; writeack = 1;
        wait_drained();
        reqack = 0; writeack = 0;
        fwd_addr = 64'h0;

        // killed store and killed ALU op
        clr_in();
        wb_valid = 1; wb_kill = 1; wb_is_store = 1; wb_dest_valid = 1; wb_dest_reg = 4'd7;
        wb_store_addr = 64'h5000;
        step();
        clr_in();
        @(negedge clk);
        chk("kst_inuse", inuse_clr, 16'h0080);
        chk("kst_done", wb_done, 1'b1);
        chk("kst_we0", rf_we0, 1'b0);
        chk("kst_count", store_count, 3'd0);
        wb_valid = 1; wb_kill = 1; wb_dest_valid = 1; wb_dest_reg = 4'd5;
        wb_spec_valid = 1; wb_spec_reg = 4'd6;
        step();
        clr_in();
        @(negedge clk);
        chk("kalu_inuse", inuse_clr, 16'h0060);
        chk("kalu_we0", rf_we0, 1'b0);
        chk("kalu_we1", rf_we1, 1'b0);
        chk("kalu_done", wb_done, 1'b1);

        // reset while waiting for writeack with 2 entries
        put_store(64'h6000, 64'h61);
        put_store(64'h6008, 64'h62);
        wait_reqcyc();
        reqack = 1; step(); reqack = 0;
        @(negedge clk);
        chk("wait_reqcyc_low", reqcyc, 1'b0);
        chk("wait_count", store_count, 3'd2);
        reset = 0;
        step();
        reset = 1;
        @(negedge clk);
        chk("mrst_reqcyc", reqcyc, 1'b0);
        chk("mrst_count", store_count, 3'd0);
        chk("mrst_drained", drained, 1'b1);
        writeack = 1; step(); writeack = 0;
        repeat (2) begin
            @(negedge clk);
            chk("late_wack_done", store_done, 1'b0);
            chk("late_wack_reqcyc", reqcyc, 1'b0);
        end

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
